// File: rtl/bch_syndrome_gen.sv
// bch_syndrome_gen
// Syndrome generator for the BCH decoder front end. Takes the received
// hard-decision codeword 8 bits per beat, MSB-first with one leading zero
// pad bit, for BCH(63,51), BCH(255,239) or BCH(1023,983). It computes
// S1..S8 and hands them to the ibm block with a one-cycle write strobe.
// The next codeword can be accumulated while ibm works on the current one.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), async active-high reset
//   i_code               00=BCH63, 01=BCH255, 10=BCH1023 (sampled on beat 0)
//   i_valid/i_data       input beat, bit7 = highest degree of the beat
//   o_ready              beat accepted when i_valid & o_ready
//   i_next_S             ibm can take the next syndrome set
//   o_clear_and_wen      one-cycle write strobe to ibm
//   o_code, o_S1..o_S8   presented syndrome set (right-justified)
//   o_all_zero           presented syndromes are all zero
module bch_syndrome_gen #(
  parameter int unsigned P  = 8,
  parameter int unsigned SW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_code,
  input  logic          i_valid,
  input  logic [P-1:0]  i_data,
  output logic          o_ready,
  input  logic          i_next_S,
  output logic          o_clear_and_wen,
  output logic [1:0]    o_code,
  output logic [SW-1:0] o_S1,
  output logic [SW-1:0] o_S2,
  output logic [SW-1:0] o_S3,
  output logic [SW-1:0] o_S4,
  output logic [SW-1:0] o_S5,
  output logic [SW-1:0] o_S6,
  output logic [SW-1:0] o_S7,
  output logic [SW-1:0] o_S8,
  output logic          o_all_zero
);

  // Largest constant exponent used: alpha^(8*7) in the S7 Horner step.
  localparam int unsigned MAXE = P * 7;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Multiply by alpha in the field selected by code.
  function automatic logic [SW-1:0] mul_x(input logic [SW-1:0] a, input logic [1:0] code);
    logic [SW-1:0] r;
    r = '0;
    case (code)
      2'b00:   r[5:0] = {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
      2'b01:   r[7:0] = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
      default: r      = {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    endcase
    return r;
  endfunction

  // Multiply by alpha^e; e is always an elaboration constant, so this folds
  // into a fixed XOR network.
  function automatic logic [SW-1:0] mul_apow(input logic [SW-1:0] a, input int unsigned e,
                                             input logic [1:0] code);
    logic [SW-1:0] r;
    r = a;
    for (int unsigned i = 0; i < MAXE; i++)
      if (i < e) r = mul_x(r, code);
    return r;
  endfunction

  // One 8-bit Horner step for syndrome S_j.
  function automatic logic [SW-1:0] horner(input logic [SW-1:0] s, input logic [P-1:0] d,
                                           input int unsigned j, input logic [1:0] code);
    logic [SW-1:0] r;
    r = mul_apow(s, P * j, code);
    for (int unsigned k = 0; k < P; k++)
      if (d[k]) r = r ^ mul_apow(SW'(1), j * k, code);
    return r;
  endfunction

  // Squaring is linear over GF(2): sum of a_i * alpha^(2i).
  function automatic logic [SW-1:0] square(input logic [SW-1:0] a, input logic [1:0] code);
    logic [SW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SW; i++)
      if (a[i]) r = r ^ mul_apow(SW'(1), 2 * i, code);
    return r;
  endfunction

  state_t        state;
  logic [6:0]    beat_cnt;
  logic [1:0]    code_q;
  logic          ibm_free;
  logic [SW-1:0] acc1, acc3, acc5, acc7;

  logic          first_beat, wide, last_beat, accept, take, load, t4_out;
  logic [1:0]    eff_code;
  logic [6:0]    last_idx;
  logic [P-1:0]  beat_data;
  logic [SW-1:0] nxt1, nxt3, nxt5, nxt7;
  logic [SW-1:0] sq2, sq4, sq6, sq8;

  always_comb begin
    first_beat = (beat_cnt == '0);
    // The code is only looked at on beat 0; later beats use the latched one.
    eff_code   = first_beat ? i_code : code_q;
    wide       = (eff_code == 2'b10);
    beat_data  = i_data;
    if (first_beat) beat_data[P-1] = 1'b0;
    case (eff_code)
      2'b00:   last_idx = 7'd7;
      2'b01:   last_idx = 7'd31;
      default: last_idx = 7'd127;
    endcase
    last_beat  = (beat_cnt == last_idx);
    o_ready    = (state == ACC);
    accept     = i_valid & o_ready;
    take       = accept & ~(first_beat & (i_code == 2'b11));
    load       = (state == DONE) & (ibm_free | i_next_S);
    nxt1       = horner(acc1, beat_data, 1, eff_code);
    nxt3       = horner(acc3, beat_data, 3, eff_code);
    nxt5       = wide ? horner(acc5, beat_data, 5, eff_code) : '0;
    nxt7       = wide ? horner(acc7, beat_data, 7, eff_code) : '0;
    t4_out     = (code_q == 2'b10);
    sq2        = square(acc1, code_q);
    sq4        = square(sq2, code_q);
    sq6        = square(acc3, code_q);
    sq8        = square(sq4, code_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= ACC;
      beat_cnt        <= '0;
      code_q          <= '0;
      ibm_free        <= 1'b1;
      acc1            <= '0;
      acc3            <= '0;
      acc5            <= '0;
      acc7            <= '0;
      o_clear_and_wen <= 1'b0;
      o_code          <= '0;
      o_S1            <= '0;
      o_S2            <= '0;
      o_S3            <= '0;
      o_S4            <= '0;
      o_S5            <= '0;
      o_S6            <= '0;
      o_S7            <= '0;
      o_S8            <= '0;
      o_all_zero      <= 1'b0;
    end else begin
      o_clear_and_wen <= load;
      // A load consumes ibm even if i_next_S arrives on the same edge.
      if (load)          ibm_free <= 1'b0;
      else if (i_next_S) ibm_free <= 1'b1;

      case (state)
        ACC: begin
          if (take) begin
            acc1 <= nxt1;
            acc3 <= nxt3;
            acc5 <= nxt5;
            acc7 <= nxt7;
            if (first_beat) code_q <= i_code;
            if (last_beat) state    <= DONE;
            else           beat_cnt <= beat_cnt + 7'd1;
          end
        end
        DONE: begin
          if (load) begin
            o_code     <= code_q;
            o_S1       <= acc1;
            o_S2       <= sq2;
            o_S3       <= acc3;
            o_S4       <= sq4;
            o_S5       <= t4_out ? acc5 : '0;
            o_S6       <= t4_out ? sq6  : '0;
            o_S7       <= t4_out ? acc7 : '0;
            o_S8       <= t4_out ? sq8  : '0;
            // Even syndromes are squares of odd ones, so the odd set decides.
            o_all_zero <= ~|{acc1, acc3, acc5, acc7};
            acc1       <= '0;
            acc3       <= '0;
            acc5       <= '0;
            acc7       <= '0;
            beat_cnt   <= '0;
            state      <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_gen.sv
module tb_bch_syndrome_gen;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_code;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       i_next_S;
  logic       o_clear_and_wen;
  logic [1:0] o_code;
  logic [9:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
  logic       o_all_zero;

  bch_syndrome_gen #(.P(8), .SW(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_code(i_code), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .i_next_S(i_next_S),
    .o_clear_and_wen(o_clear_and_wen), .o_code(o_code),
    .o_S1(o_S1), .o_S2(o_S2), .o_S3(o_S3), .o_S4(o_S4),
    .o_S5(o_S5), .o_S6(o_S6), .o_S7(o_S7), .o_S8(o_S8),
    .o_all_zero(o_all_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int double_strobes = 0;
  logic prev_wen = 1'b0;

  logic [9:0] s_obs [1:8];
  assign s_obs[1] = o_S1;
  assign s_obs[2] = o_S2;
  assign s_obs[3] = o_S3;
  assign s_obs[4] = o_S4;
  assign s_obs[5] = o_S5;
  assign s_obs[6] = o_S6;
  assign s_obs[7] = o_S7;
  assign s_obs[8] = o_S8;

  always @(negedge i_clk) begin
    if (o_clear_and_wen) strobes++;
    if (o_clear_and_wen && prev_wen) double_strobes++;
    prev_wen = o_clear_and_wen;
  end

  // Reference model: codeword as a degree-indexed bit vector, syndromes as
  // direct polynomial evaluation r(alpha^j) using antilog tables.
  bit         cw [1024];
  logic [9:0] exp_t [3][1023];
  logic [9:0] exp_s [1:8];
  logic       exp_zero;

  function automatic int unsigned code_n(input logic [1:0] c);
    case (c)
      2'b00:   return 63;
      2'b01:   return 255;
      default: return 1023;
    endcase
  endfunction

  function automatic int unsigned code_beats(input logic [1:0] c);
    return (code_n(c) + 1) / 8;
  endfunction

  task automatic build_tables();
    int unsigned m;
    logic [10:0] poly, a;
    for (int f = 0; f < 3; f++) begin
      m    = (f == 0) ? 6 : (f == 1) ? 8 : 10;
      poly = (f == 0) ? 11'h043 : (f == 1) ? 11'h11D : 11'h409;
      a    = 11'd1;
      for (int e = 0; e < (1 << m) - 1; e++) begin
        exp_t[f][e] = a[9:0];
        a = a << 1;
        if (a[m]) a = a ^ poly;
      end
    end
  endtask

  task automatic clear_cw();
    for (int i = 0; i < 1024; i++) cw[i] = 1'b0;
  endtask

  task automatic compute_expected(input logic [1:0] c);
    int unsigned n, f, tmax;
    n = code_n(c);
    f = int'(c);
    tmax = (c == 2'b10) ? 8 : 4;
    exp_zero = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      exp_s[j] = '0;
      if (j <= tmax)
        for (int i = 0; i < int'(n); i++)
          if (cw[i]) exp_s[j] = exp_s[j] ^ exp_t[f][(j * i) % n];
      if (exp_s[j] != 0) exp_zero = 1'b0;
    end
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic drive_beat(input logic [1:0] code, input logic [7:0] data, input int unsigned gap);
    bit rdy, done;
    repeat (gap) begin @(posedge i_clk); #1; end
    i_valid = 1'b1;
    i_code  = code;
    i_data  = data;
    done    = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk); #1;
      done = rdy;
    end
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    if (!done) begin
      checks++; failures++;
      $display("FAIL beat_accept got o_ready=0 want o_ready=1 within 1000 cycles");
    end
  endtask

  // Pad bit and mid-word i_code are randomised: both must be ignored.
  task automatic send_word(input logic [1:0] code, input bit gaps, input int unsigned max_beats);
    int unsigned total, n, deg;
    logic [7:0] b8;
    logic [1:0] cd;
    total = code_beats(code);
    n = code_n(code);
    for (int unsigned b = 0; b < total && b < max_beats; b++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        deg = total * 8 - 1 - (b * 8 + 7 - k);
        b8[k] = (deg < n) ? cw[deg] : 1'($urandom);
      end
      cd = (b == 0) ? code : 2'($urandom);
      drive_beat(cd, b8, gaps ? $urandom_range(0, 2) : 0);
    end
  endtask

  // Returns the number of cycles from the last accepting edge to the strobe.
  task automatic wait_strobe(output int lat);
    lat = 0;
    for (int c = 1; c <= 300 && lat == 0; c++) begin
      @(negedge i_clk);
      if (o_clear_and_wen) lat = c;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic release_ibm();
    i_next_S = 1'b1;
    @(posedge i_clk); #1;
    i_next_S = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", o_ready); end
    checks++; if (o_clear_and_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got %b want 0", o_clear_and_wen); end
    checks++; if (o_code !== 2'b00) begin failures++; $display("FAIL reset_code got %b want 00", o_code); end
    checks++; if (o_all_zero !== 1'b0) begin failures++; $display("FAIL reset_all_zero got %b want 0", o_all_zero); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== 10'h000) begin failures++; $display("FAIL reset_S%0d got %h want 000", j, s_obs[j]); end
    end
  endtask

  task automatic test_zero_word();
    int lat, s0;
    clear_cw();
    compute_expected(2'b10);
    s0 = strobes;
    send_word(2'b10, 1'b0, 1024);
    wait_strobe(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL zero_latency got %0d want 2", lat); end
    checks++; if (o_code !== 2'b10) begin failures++; $display("FAIL zero_code got %b want 10", o_code); end
    checks++; if (o_all_zero !== 1'b1) begin failures++; $display("FAIL zero_all_zero got %b want 1", o_all_zero); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== 10'h000) begin failures++; $display("FAIL zero_S%0d got %h want 000", j, s_obs[j]); end
    end
    repeat (4) begin @(posedge i_clk); #1; end
    checks++; if (strobes - s0 !== 1) begin failures++; $display("FAIL zero_strobe_count got %0d want 1", strobes - s0); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL zero_ready_after got %b want 1", o_ready); end
    release_ibm();
  endtask

  task automatic test_single_errors();
    logic [1:0]  codes [3] = '{2'b10, 2'b00, 2'b01};
    int unsigned degs  [3] = '{1, 5, 0};
    logic [9:0]  k10 [1:8] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100};
    int lat;
    for (int t = 0; t < 3; t++) begin
      clear_cw();
      cw[degs[t]] = 1'b1;
      compute_expected(codes[t]);
      send_word(codes[t], 1'b1, 1024);
      wait_strobe(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL single%0d_latency got %0d want 2", t, lat); end
      checks++; if (o_code !== codes[t]) begin failures++; $display("FAIL single%0d_code got %b want %b", t, o_code, codes[t]); end
      checks++; if (o_all_zero !== 1'b0) begin failures++; $display("FAIL single%0d_all_zero got %b want 0", t, o_all_zero); end
      for (int j = 1; j <= 8; j++) begin
        checks++;
        if (s_obs[j] !== exp_s[j]) begin failures++; $display("FAIL single%0d_S%0d got %h want %h", t, j, s_obs[j], exp_s[j]); end
        if (t == 0) begin
          checks++;
          if (s_obs[j] !== k10[j]) begin failures++; $display("FAIL single_const_S%0d got %h want %h", j, s_obs[j], k10[j]); end
        end
      end
      release_ibm();
    end
  endtask

  task automatic test_random_words();
    logic [1:0] c;
    int unsigned n, nerr, idx;
    int lat;
    for (int t = 0; t < 6; t++) begin
      c = 2'($urandom_range(0, 2));
      n = code_n(c);
      clear_cw();
      nerr = $urandom_range(0, 4);
      for (int e = 0; e < int'(nerr); e++) begin
        idx = $urandom_range(0, n - 1);
        cw[idx] = ~cw[idx];
      end
      compute_expected(c);
      send_word(c, 1'b1, 1024);
      wait_strobe(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rand%0d_latency got %0d want 2", t, lat); end
      checks++; if (o_code !== c) begin failures++; $display("FAIL rand%0d_code got %b want %b", t, o_code, c); end
      checks++; if (o_all_zero !== exp_zero) begin failures++; $display("FAIL rand%0d_all_zero got %b want %b", t, o_all_zero, exp_zero); end
      for (int j = 1; j <= 8; j++) begin
        checks++;
        if (s_obs[j] !== exp_s[j]) begin failures++; $display("FAIL rand%0d_S%0d got %h want %h", t, j, s_obs[j], exp_s[j]); end
      end
      release_ibm();
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_a [1:8];
    int lat, s0;
    clear_cw();
    cw[10] = 1'b1;
    compute_expected(2'b00);
    exp_a = exp_s;
    send_word(2'b00, 1'b0, 1024);
    wait_strobe(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
    // ibm is now busy: the second word must park in DONE.
    clear_cw();
    cw[3] = 1'b1;
    cw[200] = 1'b1;
    compute_expected(2'b01);
    s0 = strobes;
    send_word(2'b01, 1'b0, 1024);
    repeat (12) begin @(posedge i_clk); #1; end
    checks++; if (strobes !== s0) begin failures++; $display("FAIL b2b_no_strobe got %0d want %0d", strobes, s0); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_stalled_ready got %b want 0", o_ready); end
    checks++; if (o_code !== 2'b00) begin failures++; $display("FAIL b2b_held_code got %b want 00", o_code); end
    checks++; if (o_S1 !== exp_a[1]) begin failures++; $display("FAIL b2b_held_S1 got %h want %h", o_S1, exp_a[1]); end
    i_next_S = 1'b1;
    @(negedge i_clk);
    checks++; if (o_clear_and_wen !== 1'b0) begin failures++; $display("FAIL b2b_early_strobe got %b want 0", o_clear_and_wen); end
    @(posedge i_clk); #1;
    i_next_S = 1'b0;
    @(negedge i_clk);
    checks++; if (o_clear_and_wen !== 1'b1) begin failures++; $display("FAIL b2b_strobe got %b want 1", o_clear_and_wen); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got %b want 1", o_ready); end
    checks++; if (o_code !== 2'b01) begin failures++; $display("FAIL b2b_code got %b want 01", o_code); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== exp_s[j]) begin failures++; $display("FAIL b2b_S%0d got %h want %h", j, s_obs[j], exp_s[j]); end
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++; if (o_clear_and_wen !== 1'b0) begin failures++; $display("FAIL b2b_strobe_width got %b want 0", o_clear_and_wen); end
    @(posedge i_clk); #1;
    release_ibm();
  endtask

  task automatic test_invalid_code();
    int lat, s0;
    s0 = strobes;
    drive_beat(2'b11, 8'h5A, 0);
    repeat (12) begin @(posedge i_clk); #1; end
    checks++; if (strobes !== s0) begin failures++; $display("FAIL invalid_no_strobe got %0d want %0d", strobes, s0); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL invalid_ready got %b want 1", o_ready); end
    clear_cw();
    cw[20] = 1'b1;
    cw[40] = 1'b1;
    compute_expected(2'b00);
    send_word(2'b00, 1'b0, 1024);
    wait_strobe(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL invalid_next_latency got %0d want 2", lat); end
    checks++; if (o_code !== 2'b00) begin failures++; $display("FAIL invalid_next_code got %b want 00", o_code); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== exp_s[j]) begin failures++; $display("FAIL invalid_next_S%0d got %h want %h", j, s_obs[j], exp_s[j]); end
    end
    release_ibm();
  endtask

  task automatic test_reset_mid();
    int lat;
    int unsigned idx;
    clear_cw();
    cw[700] = 1'b1;
    send_word(2'b10, 1'b0, 51);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %b want 1", o_ready); end
    checks++; if (o_code !== 2'b00) begin failures++; $display("FAIL rstmid_code got %b want 00", o_code); end
    checks++; if (o_all_zero !== 1'b0) begin failures++; $display("FAIL rstmid_all_zero got %b want 0", o_all_zero); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== 10'h000) begin failures++; $display("FAIL rstmid_S%0d got %h want 000", j, s_obs[j]); end
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    clear_cw();
    for (int e = 0; e < 3; e++) begin
      idx = $urandom_range(0, 1022);
      cw[idx] = 1'b1;
    end
    compute_expected(2'b10);
    send_word(2'b10, 1'b1, 1024);
    wait_strobe(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rstmid_next_latency got %0d want 2", lat); end
    checks++; if (o_code !== 2'b10) begin failures++; $display("FAIL rstmid_next_code got %b want 10", o_code); end
    checks++; if (o_all_zero !== exp_zero) begin failures++; $display("FAIL rstmid_next_all_zero got %b want %b", o_all_zero, exp_zero); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (s_obs[j] !== exp_s[j]) begin failures++; $display("FAIL rstmid_next_S%0d got %h want %h", j, s_obs[j], exp_s[j]); end
    end
    release_ibm();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst    = 1'b0;
    i_code   = 2'b00;
    i_valid  = 1'b0;
    i_data   = 8'h00;
    i_next_S = 1'b0;
    build_tables();
    #2 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    test_reset();
    test_zero_word();
    test_single_errors();
    test_random_words();
    test_back_to_back();
    test_invalid_code();
    test_reset_mid();

    repeat (3) begin @(posedge i_clk); #1; end
    checks++;
    if (double_strobes !== 0) begin
      failures++;
      $display("FAIL strobe_consecutive got %0d want 0", double_strobes);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
